// File: rtl/lookup_index_gen_if.sv
// Sample stream and run-control bundle for lookup_index_gen.
// The master drives samples and run control. The slave returns the index, residue, clamp flag and done.
// Combinational only. There is no flow control; the consumer takes out0/out1 every cycle.
interface lookup_index_gen_if #(
  parameter int DATA_W = 32
);
  logic              run;
  logic              running;
  logic              disabled;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic              clamped;
  logic              done;

  modport master (
    output run, running, disabled, in0,
    input  out0, out1, clamped, done
  );

  modport slave (
    input  run, running, disabled, in0,
    output out0, out1, clamped, done
  );
endinterface

// File: rtl/lookup_index_gen.sv
// Converts samples into table index + fractional residue: (in0-base)>>shift, clamped to maxIndex.
// Latency: fixed 2 cycles in0 -> out0/out1/clamped; the run/delay/count window drives done.
// No backpressure: the pipeline advances every cycle. `running` low freezes only the window counters.
// Optional macro LOOKUP_INDEX_GEN_CLAMP_CNT_EN adds clampCount, the number of clamped samples in the window.
module lookup_index_gen #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  lookup_index_gen_if.slave  io,
  input  logic [DATA_W-1:0]  base,
  input  logic [4:0]         shift,
  input  logic [ADDR_W-1:0]  maxIndex,
  input  logic [CNT_W-1:0]   amount,
`ifdef LOOKUP_INDEX_GEN_CLAMP_CNT_EN
  output logic [CNT_W-1:0]   clampCount,
`endif
  input  logic [CNT_W-1:0]   delay0
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;

  // Stage 1 registers: signed difference one bit wider than the data, so it cannot overflow.
  logic signed [DATA_W:0] diff_d, diff_q;
  logic [4:0]             shift_d, shift_q;
  // Stage 2 registers
  logic [DATA_W-1:0]      out0_d, out0_q;
  logic [DATA_W-1:0]      out1_d, out1_q;
  logic                   clamped_d, clamped_q;
  // Window FSM
  logic [1:0]             state_d, state_q;
  logic [CNT_W-1:0]       dcnt_d, dcnt_q;
  logic [CNT_W-1:0]       scnt_d, scnt_q;
  logic                   done_d, done_q;

  logic [DATA_W-1:0]      mag;
  logic [DATA_W-1:0]      q;
  logic [DATA_W-1:0]      mask;
  logic [DATA_W-1:0]      max_ext;
  logic                   run_accept;

  // Stage 1: sign-extend both operands and subtract. Also capture shift for stage 2.
  always_comb begin
    diff_d  = $signed({io.in0[DATA_W-1], io.in0}) - $signed({base[DATA_W-1], base});
    shift_d = shift;
  end

  // Stage 2: negative values clamp to 0, values too large clamp to maxIndex, otherwise split into index and residue.
  always_comb begin
    mag       = diff_q[DATA_W-1:0];
    q         = mag >> shift_q;
    mask      = ~({DATA_W{1'b1}} << shift_q);
    max_ext   = {{(DATA_W-ADDR_W){1'b0}}, maxIndex};
    out0_d    = '0;
    out1_d    = '0;
    clamped_d = 1'b0;
    if (diff_q[DATA_W]) begin
      clamped_d = 1'b1;
    end else if (q > max_ext) begin
      // Compare at full width so that index bits above ADDR_W also force the clamp.
      out0_d    = max_ext;
      clamped_d = 1'b1;
    end else begin
      out0_d = {{(DATA_W-ADDR_W){1'b0}}, q[ADDR_W-1:0]};
      out1_d = mag & mask;
    end
  end

  // A run pulse restarts the window from any state. In IDLE the pulse is ignored while disabled.
  assign run_accept = io.run && ((state_q != IDLE) || !io.disabled);

  // Window FSM: wait delay0+1 running cycles, then count amount+1 running cycles, then raise done.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    scnt_d  = scnt_q;
    done_d  = done_q;
    case (state_q)
      DELAY: begin
        if (io.running) begin
          if (dcnt_q == delay0) begin
            state_d = COUNT;
            scnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      COUNT: begin
        if (io.running) begin
          if (scnt_q == amount) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      default: begin
        done_d = 1'b1;
      end
    endcase
    // A run pulse wins over a completion in the same cycle.
    if (run_accept) begin
      state_d = DELAY;
      dcnt_d  = '0;
      scnt_d  = '0;
      done_d  = 1'b0;
    end
  end

  // Pipeline and FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      shift_q   <= '0;
      out0_q    <= '0;
      out1_q    <= '0;
      clamped_q <= 1'b0;
      state_q   <= IDLE;
      dcnt_q    <= '0;
      scnt_q    <= '0;
      done_q    <= 1'b1;
    end else begin
      diff_q    <= diff_d;
      shift_q   <= shift_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      clamped_q <= clamped_d;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      scnt_q    <= scnt_d;
      done_q    <= done_d;
    end
  end

  assign io.out0    = out0_q;
  assign io.out1    = out1_q;
  assign io.clamped = clamped_q;
  assign io.done    = done_q;

`ifdef LOOKUP_INDEX_GEN_CLAMP_CNT_EN
  logic [CNT_W-1:0] ccnt_d, ccnt_q;

  // Count clamped output samples while counting the window. Saturate at the maximum and hold the value after done.
  always_comb begin
    ccnt_d = ccnt_q;
    if (run_accept) begin
      ccnt_d = '0;
    end else if ((state_q == COUNT) && io.running && clamped_q && (ccnt_q != {CNT_W{1'b1}})) begin
      ccnt_d = ccnt_q + 1'b1;
    end
  end

  // Clamp counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt_q <= '0;
    end else begin
      ccnt_q <= ccnt_d;
    end
  end

  assign clampCount = ccnt_q;
`endif

endmodule
